// File: rtl/wdb_entry_allocator.sv
// wdb_entry_allocator: WDB entry pool with one pre-allocated entry slot per write-request xbar channel
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   alloc_vld     per-channel: slot holds a valid pre-allocated entry
//   alloc_idx     per-channel: entry index held by the slot
//   alloc_rdy     per-channel: xbar consumes the slot's entry this cycle
//   rel_vld       per-port: entry returned to the pool (always accepted)
//   rel_idx       per-port: index of the returned entry
//   free_cnt      number of free entries in the pool (slot-held entries excluded)
//   err_dbl_free  sticky double-free flag
//
// Optional feature: define WDB_ALLOC_CHECK_EN to enable double-free detection
// and the index/uniqueness assertions; otherwise err_dbl_free is tied to 0.
module wdb_entry_allocator #(
    parameter int DB_ENTRY_NUM       = 32,
    parameter int DB_ENTRY_IDX_WIDTH = $clog2(DB_ENTRY_NUM),
    parameter int CH_NUM             = 4,
    parameter int REL_NUM            = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    output logic [CH_NUM-1:0]                            alloc_vld,
    output logic [CH_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]    alloc_idx,
    input  logic [CH_NUM-1:0]                            alloc_rdy,
    input  logic [REL_NUM-1:0]                           rel_vld,
    input  logic [REL_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]   rel_idx,
    output logic [DB_ENTRY_IDX_WIDTH:0]                  free_cnt,
    output logic                                         err_dbl_free
);
    localparam int W  = DB_ENTRY_IDX_WIDTH;
    localparam int PW = $clog2(CH_NUM);

    logic [DB_ENTRY_NUM-1:0] free_map, free_nxt, rel_mask, refill_oh;
    logic [CH_NUM-1:0]       elig;
    logic [PW-1:0]           rr_ptr, win;
    logic [W-1:0]            low_idx;
    logic [W:0]              cnt_nxt;
    logic                    refill;

    always_comb begin
        elig = ~alloc_vld | (alloc_vld & alloc_rdy);
        // descending scans so the lowest free bit / nearest rr channel wins
        low_idx = '0;
        for (int i = DB_ENTRY_NUM - 1; i >= 0; i--)
            if (free_map[i]) low_idx = W'(i);
        win = rr_ptr;
        for (int k = CH_NUM - 1; k >= 0; k--)
            if (elig[PW'(rr_ptr + PW'(k))]) win = PW'(rr_ptr + PW'(k));
        // refill only draws from the registered bitmap, so releases become usable next cycle
        refill    = |elig && |free_map;
        refill_oh = refill ? (DB_ENTRY_NUM'(1) << low_idx) : '0;
        rel_mask  = '0;
        for (int p = 0; p < REL_NUM; p++)
            if (rel_vld[p]) rel_mask[rel_idx[p]] = 1'b1;
        free_nxt = (free_map & ~refill_oh) | rel_mask;
        // counting the next bitmap dedups releases and ignores already-free bits
        cnt_nxt = '0;
        for (int i = 0; i < DB_ENTRY_NUM; i++)
            cnt_nxt = cnt_nxt + (W+1)'(free_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map  <= '1;
            free_cnt  <= (W+1)'(DB_ENTRY_NUM);
            alloc_vld <= '0;
            alloc_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            free_map <= free_nxt;
            free_cnt <= cnt_nxt;
            for (int i = 0; i < CH_NUM; i++) begin
                if (refill && win == PW'(i)) begin
                    alloc_vld[i] <= 1'b1;
                    alloc_idx[i] <= low_idx;
                end else if (alloc_rdy[i]) begin
                    alloc_vld[i] <= 1'b0;
                end
            end
            if (refill) rr_ptr <= win + 1'b1;
        end
    end

`ifdef WDB_ALLOC_CHECK_EN
    logic dbl;

    always_comb begin
        dbl = 1'b0;
        for (int p = 0; p < REL_NUM; p++) begin
            if (rel_vld[p] && free_map[rel_idx[p]]) dbl = 1'b1;
            for (int q = 0; q < p; q++)
                if (rel_vld[p] && rel_vld[q] && rel_idx[p] == rel_idx[q]) dbl = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_dbl_free <= 1'b0;
        else if (dbl) err_dbl_free <= 1'b1;
    end

    for (genvar g = 0; g < REL_NUM; g++) begin : g_rel_chk
        assert property (@(posedge clk) disable iff (!rst_n)
            rel_vld[g] |-> ({1'b0, rel_idx[g]} < (W+1)'(DB_ENTRY_NUM)));
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_slot_a
        for (genvar h = g + 1; h < CH_NUM; h++) begin : g_slot_b
            assert property (@(posedge clk) disable iff (!rst_n)
                (alloc_vld[g] && alloc_vld[h]) |-> (alloc_idx[g] != alloc_idx[h]));
        end
    end
`else
    assign err_dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_wdb_entry_allocator.sv
// tb_wdb_entry_allocator: scoreboard bench for wdb_entry_allocator
module tb_wdb_entry_allocator;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           alloc_vld;
    logic [3:0][4:0]      alloc_idx;
    logic [3:0]           alloc_rdy;
    logic [1:0]           rel_vld;
    logic [1:0][4:0]      rel_idx;
    logic [5:0]           free_cnt;
    logic                 err_dbl_free;

`ifdef WDB_ALLOC_CHECK_EN
    localparam logic [31:0] ERR_EXP = 32'd1;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    typedef struct packed {
        logic [1:0] ch;
        logic [4:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    wdb_entry_allocator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_vld    (alloc_vld),
        .alloc_idx    (alloc_idx),
        .alloc_rdy    (alloc_rdy),
        .rel_vld      (rel_vld),
        .rel_idx      (rel_idx),
        .free_cnt     (free_cnt),
        .err_dbl_free (err_dbl_free)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every handshake pops the next expected grant, channel order within a cycle
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (alloc_vld[i] && alloc_rdy[i]) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sb_ch", 32'(i), 32'(mon_e.ch));
                        chk("sb_idx", 32'(alloc_idx[i]), 32'(mon_e.idx));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        alloc_rdy = '0;
        rel_vld   = '0;
        rel_idx   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(alloc_vld), 32'd0);
        chk("rst_idx", 32'(alloc_idx), 32'd0);
        chk("rst_free", 32'(free_cnt), 32'd32);
        chk("rst_err", 32'(err_dbl_free), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_vld", 32'(alloc_vld), 32'((1 << (i + 1)) - 1));
            chk("fill_idx", 32'(alloc_idx[i]), 32'(i));
        end
        chk("fill_free", 32'(free_cnt), 32'd28);

        // full drain with every channel ready: one grant per cycle, ascending idx
        for (int n = 0; n < 32; n++) sb.push_back(exp_t'{ch: 2'(n % 4), idx: 5'(n)});
        alloc_rdy = 4'hf;
        for (int k = 1; k <= 28; k++) begin
            step();
            chk("drain_vld", 32'(alloc_vld), 32'(1 << ((k - 1) % 4)));
            chk("drain_idx", 32'(alloc_idx[(k - 1) % 4]), 32'(3 + k));
            chk("drain_free", 32'(free_cnt), 32'(28 - k));
        end
        step();
        chk("empty_vld", 32'(alloc_vld), 32'd0);
        chk("empty_free", 32'(free_cnt), 32'd0);
        alloc_rdy = '0;
        chk("drain_sb", 32'(sb.size()), 32'd0);

        // exhausted pool: release 7, visible in count next cycle, granted the cycle after
        rel_vld    = 2'b01;
        rel_idx[0] = 5'd7;
        step();
        rel_vld = '0;
        chk("rel7_free", 32'(free_cnt), 32'd1);
        chk("rel7_vld_lat", 32'(alloc_vld), 32'd0);
        step();
        chk("rel7_vld", 32'(alloc_vld), 32'd1);
        chk("rel7_idx", 32'(alloc_idx[0]), 32'd7);
        chk("rel7_free0", 32'(free_cnt), 32'd0);
        sb.push_back(exp_t'{ch: 2'd0, idx: 5'd7});
        alloc_rdy = 4'b0001;
        step();
        alloc_rdy = '0;

        // refill of 2 coincides with release of 9
        rel_vld    = 2'b01;
        rel_idx[0] = 5'd2;
        step();
        chk("rel2_free", 32'(free_cnt), 32'd1);
        rel_idx[0] = 5'd9;
        step();
        rel_vld = '0;
        chk("same_vld", 32'(alloc_vld), 32'b0010);
        chk("same_idx", 32'(alloc_idx[1]), 32'd2);
        chk("same_free", 32'(free_cnt), 32'd1);
        step();
        chk("rel9_vld", 32'(alloc_vld), 32'b0110);
        chk("rel9_idx", 32'(alloc_idx[2]), 32'd9);
        chk("rel9_free", 32'(free_cnt), 32'd0);
        sb.push_back(exp_t'{ch: 2'd1, idx: 5'd2});
        sb.push_back(exp_t'{ch: 2'd2, idx: 5'd9});
        alloc_rdy = 4'b0110;
        step();
        alloc_rdy = '0;
        chk("mid_sb", 32'(sb.size()), 32'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("refill_vld", 32'(alloc_vld), 32'((1 << (i + 1)) - 1));
            chk("refill_idx", 32'(alloc_idx[i]), 32'(i));
        end

        // release of an already-free entry
        rel_vld    = 2'b01;
        rel_idx[0] = 5'd5;
        step();
        rel_vld = '0;
        chk("dbl5_free", 32'(free_cnt), 32'd28);
        chk("dbl5_err", 32'(err_dbl_free), ERR_EXP);
        step();
        chk("dbl5_sticky", 32'(err_dbl_free), ERR_EXP);

        // same index on both ports counts once
        rel_vld    = 2'b11;
        rel_idx[0] = 5'd3;
        rel_idx[1] = 5'd3;
        step();
        rel_vld = '0;
        chk("dup3_free", 32'(free_cnt), 32'd29);
        chk("dup3_err", 32'(err_dbl_free), ERR_EXP);
        chk("dup3_vld", 32'(alloc_vld), 32'hf);
        chk("dup3_idx", 32'(alloc_idx[3]), 32'd3);

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(alloc_vld), 32'd0);
        chk("arst_free", 32'(free_cnt), 32'd32);
        chk("arst_err", 32'(err_dbl_free), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("restart_vld", 32'(alloc_vld), 32'd1);
        chk("restart_idx", 32'(alloc_idx[0]), 32'd0);
        chk("restart_free", 32'(free_cnt), 32'd31);

        chk("end_sb", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
